// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared types and defaults for the down-sampling address generator
package ds_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ds_state_e;

  localparam int DS_ADDR_W      = 18;
  localparam int DS_DIM_W       = 9;
  localparam int DS_SCALE       = 2;
  localparam int DS_SCALE_SHIFT = $clog2(DS_SCALE);

  function automatic int ds_shift(input int scale);
    return $clog2(scale);
  endfunction

endpackage

// File: rtl/ds_stride_counter.sv
// rtl/ds_stride_counter.sv - modulo counter stepping by STEP, flags when the next step reaches limit
module ds_stride_counter #(
  parameter int W    = 9,
  parameter int STEP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   sum;

  // One extra bit so a step past the top of a W-bit dimension still compares correctly.
  always_comb begin
    sum     = {1'b0, count_q} + (W+1)'(STEP);
    wrap    = (sum >= {1'b0, limit});
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : sum[W-1:0];
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/downsample_addr_gen.sv
// rtl/downsample_addr_gen.sv - row-major address walker emitting every SCALE-th pixel of every SCALE-th row
// Optional accepted-address counter and pix_count port under DS_AGEN_COUNT_EN.
module downsample_addr_gen
  import ds_pkg::*;
#(
  parameter int ADDR_W = DS_ADDR_W,
  parameter int DIM_W  = DS_DIM_W,
  parameter int SCALE  = DS_SCALE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic              rdy,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              busy,
  output logic              done
`ifdef DS_AGEN_COUNT_EN
  ,
  output logic [ADDR_W-1:0] pix_count
`endif
);

  localparam int SH = ds_shift(SCALE);

  ds_state_e         state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              launch;
  logic              col_wrap, row_wrap;
  logic [ADDR_W-1:0] row_stride;

  assign xfer       = (state_q == RUN) && valid_q && rdy;
  assign launch     = (state_q == IDLE) && start;
  assign row_stride = ADDR_W'(width_q) << SH;

  ds_stride_counter #(.W(DIM_W), .STEP(SCALE)) u_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (launch),
    .en    (xfer),
    .limit (width_q),
    .wrap  (col_wrap)
  );

  ds_stride_counter #(.W(DIM_W), .STEP(SCALE)) u_row (
    .clk   (clk),
    .rst   (rst),
    .clr   (launch),
    .en    (xfer && col_wrap),
    .limit (height_q),
    .wrap  (row_wrap)
  );

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          width_d  = img_width;
          height_d = img_height;
          if ((img_width == '0) || (img_height == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = RUN;
            row_base_d = base_addr;
            addr_d     = base_addr;
            valid_d    = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (col_wrap && row_wrap) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (col_wrap) begin
            row_base_d = row_base_q + row_stride;
            addr_d     = row_base_q + row_stride;
          end else begin
            addr_d = addr_q + ADDR_W'(SCALE);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      width_q    <= '0;
      height_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef DS_AGEN_COUNT_EN
  logic [ADDR_W-1:0] pix_q, pix_d;

  always_comb begin
    pix_d = pix_q;
    if (launch) begin
      pix_d = '0;
    end else if (xfer) begin
      pix_d = pix_q + 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_count = pix_q;
`endif

endmodule

// File: tb/tb_downsample_addr_gen.sv
// tb/tb_downsample_addr_gen.sv - self-checking bench for downsample_addr_gen against a pixel-grid model
module tb_downsample_addr_gen;

  localparam int AW = 18;
  localparam int DW = 9;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] img_width;
  logic [DW-1:0] img_height;
  logic          rdy;
  logic [AW-1:0] addr_out;
  logic          addr_valid;
  logic          busy;
  logic          done;
`ifdef DS_AGEN_COUNT_EN
  logic [AW-1:0] pix_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];

  downsample_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .img_width  (img_width),
    .img_height (img_height),
    .rdy        (rdy),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done)
`ifdef DS_AGEN_COUNT_EN
    ,
    .pix_count  (pix_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected addresses straight from the retained-pixel grid.
  task automatic build_expected(input logic [AW-1:0] b, input int w, input int h);
    exp_q.delete();
    for (int r = 0; r < h; r += S)
      for (int c = 0; c < w; c += S)
        exp_q.push_back(AW'(b + r * w + c));
  endtask

  task automatic issue_start(input logic [AW-1:0] b, input int w, input int h);
    @(posedge clk);
    start      = 1'b1;
    base_addr  = b;
    img_width  = DW'(w);
    img_height = DW'(h);
    @(posedge clk);
    start      = 1'b0;
    base_addr  = AW'($urandom);
    img_width  = DW'($urandom);
    img_height = DW'($urandom);
  endtask

  task automatic run_pass(input logic [AW-1:0] b, input int w, input int h,
                          input int rdy_pct, input bit glitch);
    int n, got, cyc;
    bit fin;
    build_expected(b, w, h);
    n = exp_q.size();
    issue_start(b, w, h);
    checks++;
    if (n > 0) begin
      if (addr_valid !== 1'b1 || addr_out !== exp_q[0]) begin
        failures++;
        $display("FAIL start_latency valid=%0b addr=%h required valid=1 addr=%h", addr_valid, addr_out, exp_q[0]);
      end
    end else if (done !== 1'b1 || addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_dim_done done=%0b valid=%0b required done=1 valid=0", done, addr_valid);
    end
    got = 0;
    fin = 1'b0;
    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      rdy   = ($urandom_range(99) < rdy_pct);
      start = glitch && (cyc == 2);
      checks++;
      if (busy !== addr_valid) begin
        failures++;
        $display("FAIL busy_tracks_run busy=%0b valid=%0b cycle=%0d", busy, addr_valid, cyc);
      end
      if (addr_valid && rdy) begin
        checks++;
        if (got >= n) begin
          failures++;
          $display("FAIL extra_addr addr=%h after %0d required addresses", addr_out, n);
        end else if (addr_out !== exp_q[got]) begin
          failures++;
          $display("FAIL addr_seq idx=%0d addr=%h required %h", got, addr_out, exp_q[got]);
        end
        got++;
      end
      if (done) begin
        fin = 1'b1;
        checks++;
        if (addr_valid !== 1'b0 || got != n || (rdy_pct == 100 && cyc != n)) begin
          failures++;
          $display("FAIL done_state valid=%0b count=%0d cycle=%0d required valid=0 count=%0d cycle=%0d",
                   addr_valid, got, cyc, n, n);
        end
      end
      if (!fin) @(posedge clk);
    end
    start = 1'b0;
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL pass_timeout got=%0d required %0d addresses and done", got, n);
    end
`ifdef DS_AGEN_COUNT_EN
    checks++;
    if (pix_count !== AW'(n)) begin
      failures++;
      $display("FAIL pix_count got=%0d required %0d", pix_count, n);
    end
`endif
    @(posedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_done done=%0b busy=%0b valid=%0b required all 0", done, busy, addr_valid);
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; rdy = 1'b1;
    base_addr = 18'd5; img_width = '0; img_height = '0;
    repeat (3) @(posedge clk);
    checks++;
    if (addr_out !== '0 || addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values addr=%h valid=%0b busy=%0b done=%0b required all 0", addr_out, addr_valid, busy, done);
    end
`ifdef DS_AGEN_COUNT_EN
    checks++;
    if (pix_count !== '0) begin
      failures++;
      $display("FAIL reset_pix_count got=%0d required 0", pix_count);
    end
`endif
    rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_base;       run_pass(18'd5, 4, 4, 100, 1'b0);      endtask
  task automatic test_odd;        run_pass(18'd0, 5, 3, 100, 1'b0);      endtask
  task automatic test_wrap;       run_pass(18'h3FFFF, 4, 2, 100, 1'b0);  endtask
  task automatic test_zero;
    run_pass(18'd9, 0, 4, 100, 1'b0);
    run_pass(18'd9, 6, 0, 100, 1'b0);
  endtask
  task automatic test_ignored_start; run_pass(18'd5, 6, 6, 100, 1'b1); endtask

  task automatic test_backpressure;
    int got;
    build_expected(18'd5, 4, 4);
    issue_start(18'd5, 4, 4);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== 18'd5) begin
        failures++;
        $display("FAIL backpressure_hold cycle=%0d valid=%0b addr=%h required valid=1 addr=5", i, addr_valid, addr_out);
      end
    end
    rdy = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 50 && got < exp_q.size(); cyc++) begin
      if (addr_valid) begin
        checks++;
        if (addr_out !== exp_q[got]) begin
          failures++;
          $display("FAIL backpressure_resume idx=%0d addr=%h required %h", got, addr_out, exp_q[got]);
        end
        got++;
      end
      @(posedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_done done=%0b after %0d addresses required 1", done, got);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int got;
    issue_start(18'd5, 4, 4);
    rdy = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 10 && got < 2; cyc++) begin
      if (addr_valid) got++;
      if (got < 2) @(posedge clk);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset valid=%0b busy=%0b done=%0b required all 0", addr_valid, busy, done);
    end
    @(posedge clk);
    rst = 1'b0;
    run_pass(18'd5, 4, 4, 100, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 15; k++)
      run_pass(AW'($urandom), int'($urandom_range(12)), int'($urandom_range(12)),
               int'($urandom_range(100, 40)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_base();
    test_odd();
    test_backpressure();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
